// File: rtl/pe2_stage_ctrl_pkg.sv
// Shared types and defaults for the PE2 stage controller.
// Optional stall input is enabled by PE2_STAGE_CTRL_STALL_EN.
package pe2_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    localparam int DEF_LOG_N  = 8;
    localparam int DEF_PE_LAT = 9;

endpackage

// File: rtl/pe2_addr_delay.sv
// Width/depth-parameterised shift register with async clear,
// used to align write-back strobes with the butterfly pipeline.
module pe2_addr_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe2_stage_ctrl.sv
// Sequences one in-place NTT/INTT pass through a single PE2 butterfly.
// Define PE2_STAGE_CTRL_STALL_EN to add a stall input that holds issue.
module pe2_stage_ctrl
    import pe2_stage_ctrl_pkg::*;
#(
    parameter int LOG_N  = DEF_LOG_N,
    parameter int PE_LAT = DEF_PE_LAT
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PE2_STAGE_CTRL_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_u,
    output logic [LOG_N-1:0] rd_addr_v,
    output logic [LOG_N-1:0] tw_addr,
    output logic             pe_sel,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_u,
    output logic [LOG_N-1:0] wr_addr_v
);

    localparam int SW = $clog2(LOG_N + 1);
    localparam int DW = $clog2(PE_LAT + 1);
    localparam int AW = 1 + 2 * LOG_N;

    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
    localparam logic [LOG_N-1:0] TOP    = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] J_LAST = LOG_N'((1 << (LOG_N - 1)) - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(PE_LAT - 1);
    localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);

    state_t           state;
    state_t           state_nx;
    logic [LOG_N-1:0] j;
    logic [SW-1:0]    s;
    logic [DW-1:0]    d;
    logic             mode_q;
    logic             hold;
    logic             issue;
    logic             last_j;
    logic             last_d;
    logic             last_s;
    logic [LOG_N-1:0] sh;
    logic [LOG_N-1:0] len;
    logic [LOG_N-1:0] k;
    logic [LOG_N-1:0] u;
    logic [LOG_N-1:0] v;
    logic [LOG_N-1:0] tw;

`ifdef PE2_STAGE_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign issue  = (state == RUN) && !hold;
    assign last_j = (j == J_LAST);
    assign last_d = (d == D_LAST);
    assign last_s = (s == S_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j      <= '0;
            s      <= '0;
            d      <= '0;
            mode_q <= MODE_NTT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        j      <= '0;
                        s      <= '0;
                        d      <= '0;
                        mode_q <= mode;
                    end
                end
                RUN: begin
                    if (issue) j <= last_j ? '0 : j + ONE;
                end
                DRAIN: begin
                    if (last_d) begin
                        d <= '0;
                        if (!last_s) s <= s + SW'(1);
                    end else begin
                        d <= d + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue && last_j) state_nx = DRAIN;
            DRAIN:   if (last_d) state_nx = last_s ? FIN : RUN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Butterfly span is 2**sh; twiddle base is 2**(LOG_N-1-sh) in both modes.
    always_comb begin
        sh  = (mode_q == MODE_NTT) ? TOP - LOG_N'(s) : LOG_N'(s);
        len = ONE << sh;
        k   = j >> sh;
        u   = (k << (sh + ONE)) | (j & (len - ONE));
        v   = u | len;
        tw  = (ONE << (TOP - sh)) + k;
    end

    always_comb begin
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == FIN);
        pe_sel    = (state != IDLE) && mode_q;
        rd_en     = issue;
        rd_addr_u = issue ? u  : '0;
        rd_addr_v = issue ? v  : '0;
        tw_addr   = issue ? tw : '0;
    end

    pe2_addr_delay #(
        .W     (AW),
        .DEPTH (PE_LAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_addr_u, rd_addr_v}),
        .dout ({wr_en, wr_addr_u, wr_addr_v})
    );

endmodule
